// File: rtl/tnn_feature_loader.sv
// Collects six raw samples, quantises each to 2 bits, and presents them as one feature vector.
// Optional s_last framing check is enabled by defining TNN_FEATURE_LOADER_LAST_CHECK_EN.
module tnn_feature_loader #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned THR1   = 64,
  parameter int unsigned THR2   = 128,
  parameter int unsigned THR3   = 192
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic [1:0]        feat_a,
  output logic [1:0]        feat_b,
  output logic [1:0]        feat_c,
  output logic [1:0]        feat_d,
  output logic [1:0]        feat_e,
  output logic [1:0]        feat_f,
  output logic              f_valid,
  input  logic              f_ready,
  output logic [15:0]       frames_sent,
  output logic              err
);

  localparam int unsigned NumSlots = 6;
  // Compare in at least 32 bits so thresholds above 2**DATA_W-1 still behave as unsigned.
  localparam int unsigned CmpW = (DATA_W > 32) ? DATA_W : 32;

  if (!((THR1 < THR2) && (THR2 < THR3))) begin : gen_bad_thresholds
    $error("tnn_feature_loader: thresholds must satisfy THR1 < THR2 < THR3");
  end

  typedef enum logic [0:0] {StCollect, StPresent} state_e;

  state_e      state_q;
  logic [2:0]  idx_q;
  logic [1:0]  slot_q [NumSlots];
  logic        s_ready_q;
  logic        f_valid_q;
  logic        err_q;
  logic [15:0] frames_sent_q;

  logic        accept;
  logic        frame_err;
  logic [1:0]  q_sample;

  function automatic logic [1:0] quantise(input logic [DATA_W-1:0] v);
    logic [CmpW-1:0] v_ext;
    v_ext = CmpW'(v);
    if (v_ext < CmpW'(THR1))      quantise = 2'd0;
    else if (v_ext < CmpW'(THR2)) quantise = 2'd1;
    else if (v_ext < CmpW'(THR3)) quantise = 2'd2;
    else                          quantise = 2'd3;
  endfunction

  assign accept   = s_valid && s_ready_q;
  assign q_sample = quantise(s_data);

`ifdef TNN_FEATURE_LOADER_LAST_CHECK_EN
  // s_last must be high exactly on the sixth sample of a frame.
  assign frame_err = accept && (s_last != (idx_q == 3'd5));
`else
  logic unused_s_last;
  assign unused_s_last = s_last;
  assign frame_err     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= StCollect;
      idx_q         <= 3'd0;
      s_ready_q     <= 1'b1;
      f_valid_q     <= 1'b0;
      err_q         <= 1'b0;
      frames_sent_q <= 16'd0;
      for (int i = 0; i < NumSlots; i++) begin
        slot_q[i] <= 2'd0;
      end
    end else begin
      unique case (state_q)
        StCollect: begin
          if (accept) begin
            if (frame_err) begin
              idx_q <= 3'd0;
              err_q <= 1'b1;
            end else begin
              for (int i = 0; i < NumSlots; i++) begin
                if (idx_q == 3'(i)) slot_q[i] <= q_sample;
              end
              if (idx_q == 3'd5) begin
                idx_q     <= 3'd0;
                state_q   <= StPresent;
                s_ready_q <= 1'b0;
                f_valid_q <= 1'b1;
              end else begin
                idx_q <= idx_q + 3'd1;
              end
            end
          end
        end
        StPresent: begin
          if (f_valid_q && f_ready) begin
            state_q       <= StCollect;
            s_ready_q     <= 1'b1;
            f_valid_q     <= 1'b0;
            frames_sent_q <= frames_sent_q + 16'd1;
          end
        end
        default: begin
          state_q   <= StCollect;
          s_ready_q <= 1'b1;
          f_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign s_ready     = s_ready_q;
  assign f_valid     = f_valid_q;
  assign err         = err_q;
  assign frames_sent = frames_sent_q;
  assign feat_a      = slot_q[0];
  assign feat_b      = slot_q[1];
  assign feat_c      = slot_q[2];
  assign feat_d      = slot_q[3];
  assign feat_e      = slot_q[4];
  assign feat_f      = slot_q[5];

endmodule

// File: tb/tb_tnn_feature_loader.sv
// Directed bench for tnn_feature_loader; expectations follow TNN_FEATURE_LOADER_LAST_CHECK_EN.
module tb_tnn_feature_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  s_data;
  logic        s_last;
  logic [1:0]  feat_a, feat_b, feat_c, feat_d, feat_e, feat_f;
  logic        f_valid;
  logic        f_ready;
  logic [15:0] frames_sent;
  logic        err;
  logic [11:0] fv;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // First-arriving feature sits in the top bits.
  assign fv = {feat_a, feat_b, feat_c, feat_d, feat_e, feat_f};

  tnn_feature_loader #(
    .DATA_W(8),
    .THR1  (64),
    .THR2  (128),
    .THR3  (192)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .s_last     (s_last),
    .feat_a     (feat_a),
    .feat_b     (feat_b),
    .feat_c     (feat_c),
    .feat_d     (feat_d),
    .feat_e     (feat_e),
    .feat_f     (feat_f),
    .f_valid    (f_valid),
    .f_ready    (f_ready),
    .frames_sent(frames_sent),
    .err        (err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic l);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    tick();
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                            input logic [7:0] d3, input logic [7:0] d4, input logic [7:0] d5);
    send(d0, 1'b0);
    send(d1, 1'b0);
    send(d2, 1'b0);
    send(d3, 1'b0);
    send(d4, 1'b0);
    send(d5, 1'b1);
  endtask

  task automatic take();
    f_ready = 1'b1;
    tick();
    f_ready = 1'b0;
  endtask

  initial begin
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_data  = 8'd0;
    s_last  = 1'b0;
    f_ready = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    check("rst_s_ready", 32'(s_ready), 32'd1);
    check("rst_f_valid", 32'(f_valid), 32'd0);
    check("rst_frames", 32'(frames_sent), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_feat", 32'(fv), 32'h000);

    // Basic frame with f_ready already high.
    f_ready = 1'b1;
    send_frame(8'd10, 8'd64, 8'd127, 8'd128, 8'd191, 8'd255);
    check("basic_f_valid", 32'(f_valid), 32'd1);
    check("basic_feat", 32'(fv), 32'h16B);
    check("basic_s_ready", 32'(s_ready), 32'd0);
    tick();
    f_ready = 1'b0;
    check("basic_hs_f_valid", 32'(f_valid), 32'd0);
    check("basic_hs_s_ready", 32'(s_ready), 32'd1);
    check("basic_frames", 32'(frames_sent), 32'd1);

    // Back-pressure: vector held while extra samples are offered.
    send_frame(8'd0, 8'd70, 8'd130, 8'd200, 8'd50, 8'd255);
    s_valid = 1'b1;
    s_data  = 8'd33;
    for (int i = 0; i < 5; i++) begin
      check("bp_f_valid", 32'(f_valid), 32'd1);
      check("bp_s_ready", 32'(s_ready), 32'd0);
      check("bp_feat", 32'(fv), 32'h1B3);
      tick();
    end
    s_valid = 1'b0;
    check("bp_frames_held", 32'(frames_sent), 32'd1);
    take();
    check("bp_hs_f_valid", 32'(f_valid), 32'd0);
    check("bp_hs_s_ready", 32'(s_ready), 32'd1);
    check("bp_frames", 32'(frames_sent), 32'd2);

    // Reset mid-frame discards the partial vector and the count.
    send(8'd10, 1'b0);
    send(8'd20, 1'b0);
    send(8'd30, 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst_frames", 32'(frames_sent), 32'd0);
    check("midrst_feat", 32'(fv), 32'h000);
    check("midrst_f_valid", 32'(f_valid), 32'd0);
    send_frame(8'd200, 8'd200, 8'd200, 8'd200, 8'd200, 8'd200);
    check("midrst_vec_valid", 32'(f_valid), 32'd1);
    check("midrst_vec", 32'(fv), 32'hFFF);
    take();
    check("midrst_frames_after", 32'(frames_sent), 32'd1);

    // Stall with s_valid low retains idx and partial slots.
    send(8'd63, 1'b0);
    send(8'd64, 1'b0);
    repeat (5) tick();
    check("stall_f_valid", 32'(f_valid), 32'd0);
    check("stall_partial", 32'(fv), 32'h1FF);
    send(8'd191, 1'b0);
    send(8'd192, 1'b0);
    send(8'd127, 1'b0);
    send(8'd128, 1'b1);
    check("stall_vec_valid", 32'(f_valid), 32'd1);
    check("stall_vec", 32'(fv), 32'h1B6);
    take();
    check("stall_frames", 32'(frames_sent), 32'd2);

    // Counter wrap via preloaded count.
    dut.frames_sent_q = 16'hFFFE;
    send_frame(8'd10, 8'd64, 8'd127, 8'd128, 8'd191, 8'd255);
    take();
    check("wrap_ffff", 32'(frames_sent), 32'h0000FFFF);
    send_frame(8'd10, 8'd64, 8'd127, 8'd128, 8'd191, 8'd255);
    take();
    check("wrap_zero", 32'(frames_sent), 32'h00000000);
    check("wrap_err", 32'(err), 32'd0);

    // Early s_last on the third sample.
    send(8'd0, 1'b0);
    send(8'd0, 1'b0);
    send(8'd255, 1'b1);
    send(8'd255, 1'b0);
    send(8'd100, 1'b0);
    send(8'd100, 1'b1);
`ifdef TNN_FEATURE_LOADER_LAST_CHECK_EN
    check("last_err", 32'(err), 32'd1);
    check("last_no_f_valid", 32'(f_valid), 32'd0);
    check("last_s_ready", 32'(s_ready), 32'd1);
    send_frame(8'd0, 8'd0, 8'd255, 8'd255, 8'd100, 8'd100);
    check("last_next_valid", 32'(f_valid), 32'd1);
    check("last_next_vec", 32'(fv), 32'h0F5);
    check("last_err_sticky", 32'(err), 32'd1);
    take();
`else
    check("last_err", 32'(err), 32'd0);
    check("last_f_valid", 32'(f_valid), 32'd1);
    check("last_vec", 32'(fv), 32'h0F5);
    take();
    check("last_err_after", 32'(err), 32'd0);
`endif
    check("last_frames", 32'(frames_sent), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tnn_feature_loader.md
TNN_FEATURE_LOADER -- requirements
Module: tnn_feature_loader

Interface
REQ-001 Parameter DATA_W, default 8, raw sample width in bits.
REQ-002 Parameter THR1, default 64, lower quantisation threshold.
REQ-003 Parameter THR2, default 128, middle quantisation threshold.
REQ-004 Parameter THR3, default 192, upper quantisation threshold; the block SHALL require THR1 < THR2 < THR3.
REQ-005 clk  input  1  sole clock; all state on rising edge.
REQ-006 rst_n  input  1  reset, synchronous, active-low.
REQ-007 s_valid  input  1  raw sample valid.
REQ-008 s_ready  output  1  block accepts raw sample.
REQ-009 s_data  input  DATA_W  raw unsigned feature value.
REQ-010 s_last  input  1  marks last (6th) sample of a frame.
REQ-011 feat_a..feat_f  output  2 each  quantised features 0..5, in arrival order, to the classifier inputs input_a..input_f.
REQ-012 f_valid  output  1  feature vector valid.
REQ-013 f_ready  input  1  classifier side takes vector.
REQ-014 frames_sent  output  16  count of delivered vectors.
REQ-015 err  output  1  sticky framing error.

Function
REQ-016 Quantisation SHALL be unsigned: q=0 if s_data<THR1; 1 if <THR2; 2 if <THR3; else 3.
REQ-017 FSM states SHALL be COLLECT and PRESENT; reset state COLLECT.
REQ-018 COLLECT: s_ready=1, f_valid=0; a sample is accepted when s_valid&&s_ready, its q stored at slot idx (0..5), idx increments.
REQ-019 Acceptance of slot 5 SHALL move to PRESENT; f_valid high on the next cycle (latency 1 clock from 6th accept), idx returns to 0.
REQ-020 PRESENT: s_ready=0, f_valid=1, feat_a..feat_f stable until handshake.
REQ-021 f_valid&&f_ready SHALL return FSM to COLLECT in the next cycle and increment frames_sent by 1.
REQ-022 frames_sent SHALL wrap 0xFFFF -> 0x0000 without flag.
REQ-023 f_valid SHALL never deassert without a handshake (except reset).
REQ-024 s_valid held low SHALL stall collection indefinitely with idx and partial slots retained.
REQ-025 Without an accepted sample, slot registers SHALL hold their value.

Reset
REQ-026 rst_n=0 at a rising edge SHALL set state COLLECT, idx=0, feat_a..feat_f=0, f_valid=0, frames_sent=0, err=0; s_ready=1 from the first cycle after reset release.
REQ-027 Reset mid-frame or during PRESENT SHALL discard the partial/pending vector without incrementing frames_sent.

Configuration
REQ-028 Macro TNN_FEATURE_LOADER_LAST_CHECK_EN SHALL enable framing check on s_last.
REQ-029 Defined: accepted sample with s_last=1 at idx<5, or s_last=0 at idx=5, SHALL discard the frame, set idx=0, stay in COLLECT, set err=1 (sticky until reset).
REQ-030 Not defined: s_last SHALL be ignored, err SHALL be constant 0, framing purely by count of six.

Verification
REQ-031 Samples 10,64,127,128,191,255 with f_ready=1 -> f_valid one cycle after 6th accept, feat_a..f = 0,1,1,2,2,3, frames_sent=1.
REQ-032 Full frame with f_ready=0 for 5 cycles -> f_valid and features stable 5 cycles, s_ready=0, further s_valid ignored; f_ready=1 -> COLLECT next cycle.
REQ-033 Three samples, rst_n=0 for one cycle, then six samples of 200 -> vector all 3, frames_sent=1.
REQ-034 Preload frames_sent path with 65536 frames -> frames_sent wraps to 0.
REQ-035 With LAST_CHECK_EN: s_last=1 on 3rd sample -> err=1, no f_valid; next correct 6-sample frame delivers normally with err still 1.
REQ-036 Without LAST_CHECK_EN: same stimulus -> err=0, vector delivered after 6th sample regardless of s_last.
